// File: rtl/adsr8_pkg.sv
// adsr8 shared types and constants.
// Envelope states, accumulator limits and the linear rate helper.
package adsr8_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr8_state_t;

  localparam int          ADSR8_ACC_W   = 16;
  localparam logic [7:0]  ADSR8_MID     = 8'h80;
  localparam logic [15:0] ADSR8_ACC_MAX = 16'hFFFF;

  // Linear per-tick step: rate + 1, so a rate of 0 still moves.
  function automatic logic [15:0] rate_step(
    input logic [7:0] rate
  );
    return {8'h00, rate} + 16'd1;
  endfunction

endpackage

// File: rtl/adsr8_scale.sv
// adsr8 amplitude scaler: signed-offset multiply, then re-bias to 0x80.
// Two register stages: product, then output sample with valid pulse.
module adsr8_scale
  import adsr8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_i,
  input  logic [7:0] in_data_i,
  input  logic [7:0] env_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o
);

  logic signed [8:0]  smp9;
  logic signed [16:0] smp17;
  logic signed [16:0] env17;
  logic signed [16:0] prod_d;
  logic signed [16:0] prod_q;
  logic               pv_q;
  logic [7:0]         out_q;
  logic               ov_q;
  logic               unused_prod;

  // Centre the sample on zero and scale by the envelope level.
  always_comb begin
    smp9   = $signed({1'b0, in_data_i} - 9'd128);
    smp17  = {{8{smp9[8]}}, smp9};
    env17  = {9'd0, env_i};
    prod_d = smp17 * env17;
  end

  assign unused_prod = ^{prod_q[16], prod_q[7:0]};

  // Product stage then re-biased output stage; reset drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      out_q  <= ADSR8_MID;
      ov_q   <= 1'b0;
    end else begin
      pv_q <= strobe_i;
      ov_q <= pv_q;
      if (strobe_i) prod_q <= prod_d;
      if (pv_q)     out_q  <= ADSR8_MID + prod_q[15:8];
    end
  end

  assign out_data_o  = out_q;
  assign out_valid_o = ov_q;

endmodule

// File: rtl/adsr8_env.sv
// adsr8 envelope generator: tick/sample counters, gate edge, ADSR FSM.
// ADSR8_EXP_DECAY_EN adds env_acc>>5 to decay and release steps.
module adsr8_env
  import adsr8_pkg::*;
#(
  parameter int TICK_DIV   = 256,
  parameter int SAMPLE_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gate,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic [7:0] env_level,
  output logic       busy
);

  localparam int TW = (TICK_DIV   > 2) ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLAST = SW'(SAMPLE_DIV - 1);

  logic [TW-1:0] tcnt_q;
  logic [SW-1:0] scnt_q;
  logic          tick;
  logic          strobe;
  logic          gate_q;
  logic          rise;

  adsr8_state_t           state_q, state_d;
  logic [ADSR8_ACC_W-1:0] acc_q, acc_d;
  logic [15:0]            sus;
  logic [16:0]            a_sum;
  logic [15:0]            dstep;
  logic [15:0]            rstep;

  assign tick   = (tcnt_q == TLAST);
  assign strobe = (scnt_q == SLAST);
  assign rise   = gate & ~gate_q;

  // Free-running envelope tick divider.
  always_ff @(posedge clk) begin
    if (rst)       tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else           tcnt_q <= tcnt_q + 1'b1;
  end

  // Free-running output sample divider.
  always_ff @(posedge clk) begin
    if (rst)         scnt_q <= '0;
    else if (strobe) scnt_q <= '0;
    else             scnt_q <= scnt_q + 1'b1;
  end

`ifdef ADSR8_EXP_DECAY_EN
  assign dstep = (acc_q >> 5) + rate_step(decay_rate);
  assign rstep = (acc_q >> 5) + rate_step(release_rate);
`else
  assign dstep = rate_step(decay_rate);
  assign rstep = rate_step(release_rate);
`endif

  // Gate transitions win over tick arithmetic in the same cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sus     = {sustain_level, 8'h00};
    a_sum   = {1'b0, acc_q} + {1'b0, rate_step(attack_rate)};
    if (rise) begin
      state_d = ATTACK;
    end else if (!gate && (state_q == ATTACK ||
                           state_q == DECAY  ||
                           state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick) begin
      unique case (state_q)
        IDLE: acc_d = '0;
        ATTACK: begin
          if (a_sum >= {1'b0, ADSR8_ACC_MAX}) begin
            acc_d   = ADSR8_ACC_MAX;
            state_d = DECAY;
          end else begin
            acc_d = a_sum[15:0];
          end
        end
        DECAY: begin
          if (acc_q <= sus || (acc_q - sus) <= dstep) begin
            acc_d   = sus;
            state_d = SUSTAIN;
          end else begin
            acc_d = acc_q - dstep;
          end
        end
        SUSTAIN: acc_d = sus;
        RELEASE: begin
          if (acc_q <= rstep) begin
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_q - rstep;
          end
        end
        default: begin
          acc_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Envelope state, accumulator and registered gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      gate_q  <= gate;
    end
  end

  assign env_level = acc_q[15:8];
  assign busy      = (state_q != IDLE);

  adsr8_scale u_scale (
    .clk         (clk),
    .rst         (rst),
    .strobe_i    (strobe),
    .in_data_i   (in_data),
    .env_i       (env_level),
    .out_data_o  (out_data),
    .out_valid_o (out_valid)
  );

endmodule

// File: tb/tb_adsr8_env.sv
// Self-checking bench for adsr8_env with a behavioural envelope model
// and an output scoreboard keyed on the expected valid cycle.
module tb_adsr8_env;

  localparam int TD = 4;
  localparam int SD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       gate;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [7:0] sustain_level;
  logic [7:0] release_rate;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] env_level;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  longint cyc = 0;

  typedef struct {
    int st;
    int acc;
    int tcnt;
    int scnt;
    bit gd;
  } mdl_t;

  typedef struct {
    int     data;
    longint cyc;
  } exp_t;

  mdl_t m = '{st: 0, acc: 0, tcnt: 0, scnt: 0, gd: 1'b0};
  exp_t sbq[$];

  adsr8_env #(.TICK_DIV(TD), .SAMPLE_DIV(SD)) dut (
    .clk           (clk),
    .rst           (rst),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .in_data       (in_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .env_level     (env_level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_out(input int d, input int e);
    int p;
    p = (d - 128) * e;
    return 128 + (p >>> 8);
  endfunction

  // States: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  function automatic mdl_t mstep(input mdl_t c, input bit g,
                                 input int ar, input int dr,
                                 input int sl, input int rr);
    mdl_t n;
    bit   tk;
    int   s, ds, rs;
    n  = c;
    tk = (c.tcnt == TD - 1);
    s  = sl * 256;
    ds = dr + 1;
    rs = rr + 1;
`ifdef ADSR8_EXP_DECAY_EN
    ds += c.acc / 32;
    rs += c.acc / 32;
`endif
    n.tcnt = tk ? 0 : c.tcnt + 1;
    n.scnt = (c.scnt == SD - 1) ? 0 : c.scnt + 1;
    n.gd   = g;
    if (g && !c.gd) begin
      n.st = 1;
    end else if (!g && c.st >= 1 && c.st <= 3) begin
      n.st = 4;
    end else if (tk) begin
      case (c.st)
        1: begin
          n.acc = c.acc + ar + 1;
          if (n.acc >= 65535) begin n.acc = 65535; n.st = 2; end
        end
        2: begin
          n.acc = c.acc - ds;
          if (n.acc <= s) begin n.acc = s; n.st = 3; end
        end
        3: n.acc = s;
        4: begin
          n.acc = c.acc - rs;
          if (n.acc <= 0) begin n.acc = 0; n.st = 0; end
        end
        default: n.acc = 0;
      endcase
    end
    return n;
  endfunction

  // Reference model; pushes the expected sample on each strobe.
  always @(posedge clk) begin
    if (rst) begin
      m <= '{st: 0, acc: 0, tcnt: 0, scnt: 0, gd: 1'b0};
      sbq.delete();
    end else begin
      if (m.scnt == SD - 1)
        sbq.push_back('{exp_out(int'(in_data), m.acc >> 8), cyc + 2});
      m <= mstep(m, gate, int'(attack_rate), int'(decay_rate),
                 int'(sustain_level), int'(release_rate));
    end
    cyc <= cyc + 1;
  end

  // Monitor: envelope, busy and scoreboard pop.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("env", {24'd0, env_level}, m.acc >> 8);
      chk("busy", {31'd0, busy}, (m.st != 0) ? 1 : 0);
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        chk("valid", {31'd0, out_valid}, 1);
        chk("out", {24'd0, out_data}, sbq[0].data);
        void'(sbq.pop_front());
      end else begin
        chk("novalid", {31'd0, out_valid}, 0);
      end
    end
  end

  task automatic wait_env(input logic [7:0] lvl, input int lim,
                          input string tag);
    int k;
    k = 0;
    while (env_level !== lvl && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {24'd0, env_level}, {24'd0, lvl});
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 2 * SD) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, out_valid}, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int mpre;
    rst = 1'b1;
    gate = 1'b0;
    attack_rate = 8'h00;
    decay_rate = 8'h00;
    sustain_level = 8'h00;
    release_rate = 8'h00;
    in_data = 8'hFF;
    repeat (4) @(negedge clk);
    chk("rst_out", {24'd0, out_data}, 32'h80);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_env", {24'd0, env_level}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    mon_en = 1'b1;
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 64);
    chk("first_valid_cyc", n, SD + 1);
    chk("idle_out", {24'd0, out_data}, 32'h80);

    attack_rate = 8'hFF;
    decay_rate = 8'h0F;
    sustain_level = 8'h40;
    release_rate = 8'h3F;
    gate = 1'b1;
    @(negedge clk);
    chk("att_busy", {31'd0, busy}, 1);
    wait_env(8'hFF, 256 * TD + 16, "att_peak");
    n = 0;
    while (!(out_valid === 1'b1 && out_data === 8'hFE) && n < 4 * SD) begin
      @(negedge clk);
      n++;
    end
    chk("peak_out", {24'd0, out_data}, 32'hFE);

    wait_env(8'h40, 14000, "dec_reach");
    repeat (20 * TD) @(negedge clk);
    chk("sus_hold", {24'd0, env_level}, 32'h40);
    in_data = 8'h00;
    wait_valid("sus_v1");
    wait_valid("sus_v2");
    chk("sus_out", {24'd0, out_data}, 32'h60);
    sustain_level = 8'h20;
    repeat (TD + 1) @(negedge clk);
    chk("sus_live", {24'd0, env_level}, 32'h20);
    sustain_level = 8'h40;
    repeat (TD + 1) @(negedge clk);
    chk("sus_back", {24'd0, env_level}, 32'h40);

    in_data = 8'h13;
    gate = 1'b0;
    @(negedge clk);
    chk("rel_busy", {31'd0, busy}, 1);
    n = 1;
    while (busy !== 1'b0 && n < 260 * TD) begin
      @(negedge clk);
      n++;
    end
    chk("rel_idle", {31'd0, busy}, 0);
`ifndef ADSR8_EXP_DECAY_EN
    chk("rel_len", (n >= 255 * TD && n <= 257 * TD) ? 1 : 0, 1);
`endif
    chk("rel_env", {24'd0, env_level}, 0);
    wait_valid("rel_v1");
    wait_valid("rel_v2");
    chk("rel_out", {24'd0, out_data}, 32'h80);

    attack_rate = 8'h3F;
    release_rate = 8'h03;
    gate = 1'b1;
    repeat (50 * TD) @(negedge clk);
    gate = 1'b0;
    repeat (10 * TD) @(negedge clk);
    chk("retrig_rel", {31'd0, busy}, 1);
    n = 0;
    while (m.tcnt != TD - 1 && n < 2 * TD) begin
      @(negedge clk);
      n++;
    end
    mpre = m.acc;
    gate = 1'b1;
    repeat (5 * TD) @(negedge clk);
    chk("retrig_kept", (env_level != 8'h00) ? 1 : 0, 1);
    chk("retrig_env", {24'd0, env_level}, (mpre + 4 * 64) >> 8);

    n = 0;
    while (m.scnt != 0 && n < 2 * SD) begin
      @(negedge clk);
      n++;
    end
    chk("mid_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    gate = 1'b0;
    @(negedge clk);
    chk("mid_valid", {31'd0, out_valid}, 0);
    chk("mid_out", {24'd0, out_data}, 32'h80);
    chk("mid_env", {24'd0, env_level}, 0);
    chk("mid_bsy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("mid_valid2", {31'd0, out_valid}, 0);
    rst = 1'b0;
    repeat (3 * SD) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adsr8_env.md
# adsr8_env

8-bit ADSR envelope generator and amplitude scaler that sits directly upstream of the 8-bit PWM DAC. It takes an unsigned offset-binary oscillator sample, shapes its amplitude with a gate-driven attack/decay/sustain/release envelope, and presents one stable 8-bit sample per PWM period on `out_data`, which drives the DAC's `in_data`.

## Interface
- `TICK_DIV`, 256: clocks per envelope tick, must be ≥2.
- `SAMPLE_DIV`, 256: clocks per output sample. Equals the DAC's 8-bit counter period.
- `clk` in 1: system clock, rising edge only.
- `rst` in 1: reset, synchronous and active-high.
- `gate` in 1: note-on level. Rising edge triggers; low releases.
- `attack_rate` in 8: attack step is `attack_rate+1` per tick.
- `decay_rate` in 8: decay step is `decay_rate+1` per tick.
- `sustain_level` in 8: sustain target, compared as `{sustain_level,8'h00}`.
- `release_rate` in 8: release step is `release_rate+1` per tick.
- `in_data` in 8: oscillator sample, unsigned, 0x80 = zero.
- `out_data` out 8: scaled sample to the DAC, unsigned, 0x80 = silence.
- `out_valid` out 1: one-cycle pulse when `out_data` updates.
- `env_level` out 8: current envelope, `env_acc[15:8]`.
- `busy` out 1: high when state ≠ IDLE.

## Operation
- **Envelope state.** 16-bit accumulator `env_acc`. States are IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- **Gate edge detect.** Uses a registered `gate_d`:
  - rise = `gate & ~gate_d`
  - fall = `~gate & gate_d`
- **Transitions.** Evaluated every clock, independent of the tick:
  - rise in any state → ATTACK. `env_acc` is kept, so a retrigger starts from the current level.
  - `gate` low in ATTACK, DECAY or SUSTAIN → RELEASE.
  - If rise and `gate` low can coincide, rise wins.
- **Arithmetic on each tick,** using the state at the start of that cycle:
  - **ATTACK:** `env_acc += step`, saturating at 0xFFFF. On reaching 0xFFFF → DECAY.
  - **DECAY:** `env_acc -= step`, clamped at `S={sustain_level,8'h00}`. On reaching S → SUSTAIN. If `env_acc` is already ≤ S on entry, load S and go to SUSTAIN on the first tick.
  - **SUSTAIN:** `env_acc` tracks S, reloaded each tick so live `sustain_level` changes apply.
  - **RELEASE:** `env_acc -= step`, clamped at 0. On reaching 0 → IDLE.
  - **IDLE:** `env_acc` held at 0.
- **Tick coinciding with a transition.** The transition takes effect and that tick's arithmetic is skipped. The new state's arithmetic begins on the next tick.
- **Scaling.**
  - `p = $signed({1'b0,in_data}-9'd128) * $signed({1'b0,env_level})`, a 17-bit product.
  - `out_data = 8'h80 + p[15:8]`, with `p>>>8` in [-128,126]. No saturation is required.
  - `env_level=0xFF`, `in_data=0xFF` gives `0x80+0x7E=0xFE`.
- **Rate inputs.** Sampled live each tick; no internal latching.

## Timing
- **Reset values:**
  - state IDLE
  - `env_acc` 0, tick counter 0, sample counter 0, `gate_d` 0
  - `out_data` 0x80, `out_valid` 0, `env_level` 0, `busy` 0
- **Envelope tick.** Counter 0..TICK_DIV-1. Tick is asserted in the cycle the counter equals TICK_DIV-1.
- **Sample strobe.** Counter 0..SAMPLE_DIV-1. Strobe in the cycle the counter equals SAMPLE_DIV-1.
- **Output pipeline latency:**
  - strobe cycle N: `in_data` and `env_level` are captured.
  - N+1: product register loads.
  - N+2: `out_data` loads and `out_valid` pulses for one cycle.
- `out_data` is constant between `out_valid` pulses.
- **Gate latency.** A `gate` change at cycle N changes the state at N+1. `busy` follows the registered state.
- **Reset mid-note.** Synchronous `rst` at any cycle forces all reset values at the next edge. This includes an in-flight pipeline sample, which is discarded.

## Configuration
- `ADSR8_EXP_DECAY_EN` defined: decay and release use step `(env_acc>>5) + rate + 1`, giving an exponential-like shape. Clamping rules are unchanged.
- `ADSR8_EXP_DECAY_EN` undefined: linear steps as above. Attack is always linear.

## Structure
- **Package `adsr8_pkg`:**
  - `adsr8_state_t` enum (IDLE=0, ATTACK, DECAY, SUSTAIN, RELEASE)
  - `ADSR8_MID = 8'h80`
  - `ADSR8_ACC_MAX = 16'hFFFF`
  - `ADSR8_ACC_W = 16`
- **Sub-module `adsr8_scale`:** the registered signed-offset multiply and re-bias, covering pipeline stages N+1 and N+2.
- **Top level:** counters, edge detect, FSM and accumulator.

## Test plan
- **Reset.** Hold `rst` 4 cycles, then release with `gate=0` → `out_data=0x80`, `busy=0`, `env_level=0`. `out_valid` first pulses at cycle SAMPLE_DIV+1 after release.
- **Full attack.** `attack_rate=0xFF` (step 256), `gate` 0→1 → ATTACK for 256 ticks. `env_level` reaches 0xFF, then DECAY. With `in_data=0xFF`, `out_data` reaches 0xFE.
- **Decay to sustain.** `decay_rate=0x0F`, `sustain_level=0x40` → DECAY clamps at `env_acc=0x4000`, then SUSTAIN. Changing `sustain_level` to 0x20 in SUSTAIN gives `env_level=0x20` on the next tick.
- **Release.** `gate` 1→0 in SUSTAIN at 0x4000 with `release_rate=0x3F` → 256 ticks to 0, then IDLE and `busy=0`. `out_data=0x80` for any `in_data`.
- **Retrigger.** `gate` fall, then rise 10 ticks later → ATTACK resumes from the current `env_acc` without resetting to 0. A `gate` change coinciding with a tick skips that tick's arithmetic.
- **Mid-note reset.** Assert `rst` during ATTACK and one cycle after a strobe → no `out_valid` pulse appears, and all outputs show reset values.
